snk_sound_cmd_latch: RTL and testbench

//  Main-CPU -> sound-CPU command channel of the SNK board core; sits between the main CPU bus decode and the sound CPU.

---
 rtl/snk_snd_pkg.sv | 18 +
 rtl/snk_strobe_edge.sv | 41 ++++
 rtl/snk_sound_cmd_latch.sv | 208 ++++++++++++++++++++
 tb/tb_snk_sound_cmd_latch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/snk_snd_pkg.sv
// Shared types and defaults for the SNK main-to-sound command channel.
// Contents:
//   cmd_t           8-bit command byte
//   NMI_PULSE_DEF   default NMI low width in clock cycles
//   FIFO_DEPTH_DEF  default command FIFO depth (SND_CMD_FIFO_EN builds only)
//   ptr_w()         FIFO index width for a given depth, without the wrap bit
package snk_snd_pkg;

    typedef logic [7:0] cmd_t;

    localparam int NMI_PULSE_DEF  = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/snk_strobe_edge.sv
// Rising-edge detector for an active-low bus strobe, qualified by the bus clock enable.
// Ports:
//   Clk     in  system clock
//   RESETn  in  asynchronous active-low reset
//   Cen     in  bus clock enable; the strobe is only sampled when high
//   STBn    in  active-low strobe
//   EDGE    out one-cycle pulse: strobe seen high now after a low sample
// The history flop resets to 1, so a strobe held low through reset release
// produces no edge until it has been sampled low at least once.
module snk_strobe_edge (
    input  logic Clk,
    input  logic RESETn,
    input  logic Cen,
    input  logic STBn,
    output logic EDGE
);

    logic prev_q;
    logic prev_d;

    // Next value of the strobe history: only advances on enabled bus cycles.
    always_comb begin
        if (Cen) begin
            prev_d = STBn;
        end else begin
            prev_d = prev_q;
        end
    end

    // Strobe history register.
    always_ff @(posedge Clk or negedge RESETn) begin
        if (!RESETn) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign EDGE = Cen & STBn & ~prev_q;

endmodule

// File: rtl/snk_sound_cmd_latch.sv
// Main-CPU -> sound-CPU command channel of the SNK board core.
// A rising edge of the main-CPU write strobe captures a command byte, flags it
// pending and fires a fixed-width NMI at the sound CPU; a sound-CPU read edge
// clears pending. Writes that find no free slot raise a sticky overrun flag.
// Build option:
//   SND_CMD_FIFO_EN  undefined: single LS273-style register (board-accurate)
//                    defined:   FIFO_DEPTH-entry command FIFO
// Ports:
//   Clk       in   system clock
//   RESETn    in   asynchronous active-low reset
//   Cen       in   bus clock enable for strobe sampling
//   MAIN_WRn  in   main-CPU command write strobe, active-low
//   MAIN_D    in   main-CPU data bus
//   SND_RDn   in   sound-CPU command read strobe, active-low
//   SND_CLRn  in   sound-CPU clear of pending/overrun, active-low level
//   SND_Q     out  command byte presented to the sound CPU
//   SND_NMIn  out  sound-CPU NMI, active-low
//   PENDING   out  unread command present
//   OVERRUN   out  sticky: a write found no free slot
module snk_sound_cmd_latch
    import snk_snd_pkg::*;
#(
    parameter int NMI_PULSE = NMI_PULSE_DEF
`ifdef SND_CMD_FIFO_EN
    ,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
`endif
) (
    input  logic       Clk,
    input  logic       RESETn,
    input  logic       Cen,
    input  logic       MAIN_WRn,
    input  logic [7:0] MAIN_D,
    input  logic       SND_RDn,
    input  logic       SND_CLRn,
    output logic [7:0] SND_Q,
    output logic       SND_NMIn,
    output logic       PENDING,
    output logic       OVERRUN
);

    localparam int CW = $clog2(NMI_PULSE + 1);

    logic          wr_edge_s;
    logic          rd_edge_s;
    logic          wr_accept_s;
    cmd_t          snd_q_q,   snd_q_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          nmi_n_q,   nmi_n_d;

    snk_strobe_edge u_wr_edge (
        .Clk    (Clk),
        .RESETn (RESETn),
        .Cen    (Cen),
        .STBn   (MAIN_WRn),
        .EDGE   (wr_edge_s)
    );

    snk_strobe_edge u_rd_edge (
        .Clk    (Clk),
        .RESETn (RESETn),
        .Cen    (Cen),
        .STBn   (SND_RDn),
        .EDGE   (rd_edge_s)
    );

`ifdef SND_CMD_FIFO_EN
    localparam int PW = ptr_w(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    cmd_t        mem_q [FIFO_DEPTH];
    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic        push_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    // A clear empties the FIFO, so a pop in the same cycle is moot and a push always fits.
    assign pop_s   = rd_edge_s && !empty_s && SND_CLRn;
    assign push_s  = wr_edge_s && (!full_s || pop_s || !SND_CLRn);

    // FIFO pointer, head-byte and flag next-state.
    always_comb begin
        wr_accept_s = push_s;

        if (!SND_CLRn) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // When the FIFO ends up empty the last presented byte is held; when the
        // new head is the slot being written this cycle, bypass the memory.
        if (wr_ptr_d == rd_ptr_d) begin
            snd_q_d = snd_q_q;
        end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            snd_q_d = MAIN_D;
        end else begin
            snd_q_d = mem_q[rd_ptr_d[PW-1:0]];
        end

        pending_d = (wr_ptr_d != rd_ptr_d);

        if (!SND_CLRn) begin
            overrun_d = 1'b0;
        end else if (wr_edge_s && !push_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // FIFO pointer registers.
    always_ff @(posedge Clk or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[PW-1:0]] <= MAIN_D;
        end
    end
`else
    // Single-register next-state: a write always lands, overwriting unread data.
    always_comb begin
        wr_accept_s = wr_edge_s;

        if (wr_edge_s) begin
            snd_q_d = MAIN_D;
        end else begin
            snd_q_d = snd_q_q;
        end

        if (wr_edge_s) begin
            pending_d = 1'b1;
        end else if (rd_edge_s || !SND_CLRn) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        if (!SND_CLRn) begin
            overrun_d = 1'b0;
        end else if (wr_edge_s && pending_q) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end
`endif

    // NMI width counter: reloads on every accepted write, counts down to 0 and stops.
    // The NMI flop follows the counter's next value so it drops together with PENDING.
    always_comb begin
        if (wr_accept_s) begin
            cnt_d = CW'(NMI_PULSE);
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        nmi_n_d = (cnt_d == {CW{1'b0}});
    end

    // Output and state registers.
    always_ff @(posedge Clk or negedge RESETn) begin
        if (!RESETn) begin
            snd_q_q   <= 8'h00;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            nmi_n_q   <= 1'b1;
        end else begin
            snd_q_q   <= snd_q_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            nmi_n_q   <= nmi_n_d;
        end
    end

    assign SND_Q    = snd_q_q;
    assign SND_NMIn = nmi_n_q;
    assign PENDING  = pending_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_snk_sound_cmd_latch.sv
// Bench for snk_sound_cmd_latch: directed scenarios plus random strobes, all
// outputs compared every cycle against a behavioural model. Honors SND_CMD_FIFO_EN.
module tb_snk_sound_cmd_latch;

    localparam int PULSE = 16;
    localparam int DEPTH = 4;

    logic       Clk = 1'b0;
    logic       RESETn;
    logic       Cen;
    logic       MAIN_WRn;
    logic [7:0] MAIN_D;
    logic       SND_RDn;
    logic       SND_CLRn;
    logic [7:0] SND_Q;
    logic       SND_NMIn;
    logic       PENDING;
    logic       OVERRUN;

    int vectors   = 0;
    int miscompares = 0;

    // Model state: the last Cen-sampled strobe levels, the command store and
    // the cycle index of the most recent accepted write (NMI is low for PULSE
    // cycles starting with the cycle in which the write becomes visible).
    bit         m_prev_wr, m_prev_rd;
    bit         m_pend, m_ovr;
    logic [7:0] m_q;
    logic [7:0] m_fifo [$];
    int         cyc;
    int         last_wr;

    snk_sound_cmd_latch dut (
        .Clk      (Clk),
        .RESETn   (RESETn),
        .Cen      (Cen),
        .MAIN_WRn (MAIN_WRn),
        .MAIN_D   (MAIN_D),
        .SND_RDn  (SND_RDn),
        .SND_CLRn (SND_CLRn),
        .SND_Q    (SND_Q),
        .SND_NMIn (SND_NMIn),
        .PENDING  (PENDING),
        .OVERRUN  (OVERRUN)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_nmi_n();
        return !(((cyc - last_wr) >= 0) && ((cyc - last_wr) < PULSE));
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".snd_q"},   SND_Q,    m_q);
        chk({tag, ".nmi_n"},   SND_NMIn, exp_nmi_n());
        chk({tag, ".pending"}, PENDING,  m_pend);
        chk({tag, ".overrun"}, OVERRUN,  m_ovr);
    endtask

    task automatic model_reset();
        m_prev_wr = 1'b1;
        m_prev_rd = 1'b1;
        m_pend    = 1'b0;
        m_ovr     = 1'b0;
        m_q       = 8'h00;
        m_fifo.delete();
        last_wr   = cyc - 1000;
    endtask

    // Apply one clock cycle of inputs, advance the model, then compare.
    task automatic step(input bit c, input bit w, input logic [7:0] d, input bit r, input bit cl,
                        input string tag);
        bit we, re;
        Cen = c; MAIN_WRn = w; MAIN_D = d; SND_RDn = r; SND_CLRn = cl;
        we = c && w && !m_prev_wr;
        re = c && r && !m_prev_rd;
        if (c) begin
            m_prev_wr = w;
            m_prev_rd = r;
        end
        cyc++;
`ifdef SND_CMD_FIFO_EN
        if (!cl) m_fifo.delete();
        else if (re && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (we) begin
            if (m_fifo.size() < DEPTH) begin
                m_fifo.push_back(d);
                last_wr = cyc;
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (!cl) m_ovr = 1'b0;
        if (m_fifo.size() > 0) m_q = m_fifo[0];
        m_pend = (m_fifo.size() > 0);
`else
        if (we) begin
            if (m_pend) m_ovr = 1'b1;
            m_q     = d;
            m_pend  = 1'b1;
            last_wr = cyc;
        end else if (re || !cl) begin
            m_pend = 1'b0;
        end
        if (!cl) m_ovr = 1'b0;
`endif
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    task automatic write_cmd(input logic [7:0] d, input string tag);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, tag);
        step(1'b1, 1'b1, d,     1'b1, 1'b1, tag);
    endtask

    task automatic read_cmd(input string tag);
        step(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, tag);
        step(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, tag);
    endtask

    initial begin
        int low_cnt;
        cyc = 0;
        model_reset();

        // Reset with the write strobe held low.
        RESETn = 1'b0; Cen = 1'b1; MAIN_WRn = 1'b0; MAIN_D = 8'h77;
        SND_RDn = 1'b1; SND_CLRn = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_all("reset");

        // Strobe rises right at release without a low sample: no capture.
        @(negedge Clk);
        RESETn = 1'b1;
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, "rel_no_edge");
        chk("rel_no_capture", PENDING, 1'b0);
        write_cmd(8'h77, "rel_edge");
        chk("rel_capture", SND_Q, 8'h77);
        step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "clr0");

        // Write 0xA5 and measure the NMI width.
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, "a5");
        step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, "a5");
        chk("a5_q", SND_Q, 8'hA5);
        chk("a5_pending", PENDING, 1'b1);
        low_cnt = (SND_NMIn === 1'b0) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, "a5_nmi");
            if (SND_NMIn === 1'b0) low_cnt++;
        end
        chk("nmi_width", low_cnt, PULSE);
        read_cmd("a5_read");
        chk("a5_read_pending", PENDING, 1'b0);
        chk("a5_read_hold", SND_Q, 8'hA5);

`ifndef SND_CMD_FIFO_EN
        // Overwrite without read, then clear.
        write_cmd(8'h11, "ovr");
        write_cmd(8'h22, "ovr");
        chk("ovr_q", SND_Q, 8'h22);
        chk("ovr_flag", OVERRUN, 1'b1);
        step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "clr");
        chk("clr_pending", PENDING, 1'b0);
        chk("clr_overrun", OVERRUN, 1'b0);

        // Write and read edges in the same cycle while pending.
        write_cmd(8'h55, "sim_pre");
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "sim");
        step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, "sim");
        chk("sim_pending", PENDING, 1'b1);
        chk("sim_q", SND_Q, 8'h3C);
        chk("sim_overrun", OVERRUN, 1'b1);
        step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "clr2");
`else
        // Fill beyond depth, then drain.
        step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "f_clr");
        for (int i = 1; i <= 5; i++) write_cmd(8'(i), "f_push");
        chk("f_overrun", OVERRUN, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            chk("f_head", SND_Q, 32'(i));
            read_cmd("f_pop");
        end
        chk("f_empty", PENDING, 1'b0);
        chk("f_hold", SND_Q, 8'h04);
        step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "f_clr2");
`endif

        // Reset asserted five cycles into an NMI pulse.
        write_cmd(8'h9E, "mid");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, "mid_pulse");
        #2;
        RESETn = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_nmi", SND_NMIn, 1'b1);
        chk("mid_rst_pending", PENDING, 1'b0);
        chk("mid_rst_q", SND_Q, 8'h00);
        chk("mid_rst_overrun", OVERRUN, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        check_all("mid_rst_hold");
        @(negedge Clk);
        RESETn = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, "mid_no_resume");

        // Random strobe traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
